fir_out_collector: RTL and testbench
====================================

Name: fir_out_collector

Overview:
- Downstream stage of the FIR / matrix-multiply engine. Consumes its AXI-Stream master output (y samples) into an on-chip FIFO.
- Exposes the FIFO, status, sample count and a completion flag to the CPU over a Wishbone slave.
- Stops accepting data after tlast until software re-arms it, so results of one run are never mixed with the next.

Parameters:
- pDATA_WIDTH, 32, stream/Wishbone data width.
- DEPTH, 16, FIFO entries; power of two, 2..256.
- CNT_WIDTH, 16, width of the accepted-sample counter.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables; writes use byte 0 only.
- wbs_dat_i  in  32  write data.
- wbs_adr_i  in  32  address; only [3:2] decoded.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- sm_tvalid  in  1  upstream sample valid.
- sm_tdata  in  pDATA_WIDTH  upstream sample.
- sm_tlast  in  1  last sample of run.
- sm_tready  out  1  accept.
- done_irq  out  1  level interrupt, equals the DONE bit.

Behaviour:
- Reset (rst=1 at posedge):
  - state=RUN; FIFO empty; count=0; underflow=0.
  - Outputs: wbs_ack_o=0, wbs_dat_o=0, done_irq=0, sm_tready=1 (combinational from state and full).
- States:
  - RUN: sm_tready = !full.
  - HOLD: sm_tready=0, DONE=1.
  - RUN->HOLD when sm_tvalid & sm_tready & sm_tlast; the tlast sample itself is stored.
  - HOLD->RUN on a write of CTRL bit1 (rearm) or bit0 (clear).
- Stream push: a sample is accepted when sm_tvalid & sm_tready. It is written at the write pointer, occupancy +1, count +1 (wraps at 2^CNT_WIDTH).
- sm_tready depends only on registered occupancy and state. A same-cycle pop never admits a push while full.
- Wishbone access:
  - A request is stb & cyc & !wbs_ack_o.
  - wbs_ack_o pulses 1 cycle, registered, in the cycle after the request, so minimum spacing between accesses is 2 cycles.
  - wbs_dat_o is registered alongside the ack and holds 0 otherwise.
- Address map (adr[3:2]):
  - 0 DATA (R): returns the FIFO head and pops it. If empty: returns 0, no pop, sets sticky underflow.
  - 1 STATUS (R):
    - bit0 empty
    - bit1 full
    - bit2 DONE
    - bit3 underflow
    - bits[15:8] occupancy (zero-extended)
    - other bits 0
  - 1 CTRL (W), wbs_sel_i[0] required:
    - bit0 clear: flush FIFO, count=0, underflow=0, state=RUN.
    - bit1 rearm: state=RUN, FIFO kept.
    - Clear wins if both bits are set.
  - 2 COUNT (R): count zero-extended.
  - 3 CKSUM (R): see Optional Feature. Reads 0 when the feature is absent.
  - Writes to DATA, COUNT or CKSUM are acked and ignored.
- Simultaneous push and pop: both take effect and occupancy is unchanged. On an empty FIFO a pop never returns same-cycle push data (no bypass).
- Clear in the same cycle as a push: clear wins and the sample is dropped. The upstream sees sm_tready=1 that cycle; this is documented as software's responsibility (clear only when upstream is idle).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Occupancy is log2(DEPTH)+1 bits.
- Latency: accepted sample is visible at DATA on the next access issued ≥1 cycle after acceptance.

Optional Feature:
- Macro: FIR_OUT_COLLECTOR_CKSUM_EN.
- Defined:
  - 32-bit register cksum += sm_tdata (modulo 2^32) on every push.
  - Cleared by reset and CTRL.clear.
  - Readable at adr[3:2]=3.
- Undefined: no register; address 3 reads 0.

Decomposition:
- Shared package holds:
  - Register offsets (ADR_DATA=0, ADR_STATUS=1, ADR_COUNT=2, ADR_CKSUM=3).
  - STATUS bit positions and CTRL bit positions (CTRL_CLEAR=0, CTRL_REARM=1).
  - State encoding RUN=1'b0, HOLD=1'b1.
- One natural sub-module: sync_fifo (parameterised width/depth, push/pop/flush, full/empty/occupancy). Top holds FSM, counter, checksum and Wishbone decode.

Test Plan:
- Reset, push 5 samples 1..5 with tlast on 5 -> sm_tready drops the cycle after 5 is accepted; STATUS=0x0000_0504 (occupancy 5, DONE); done_irq=1; COUNT=5.
- Five DATA reads after the previous case -> return 1,2,3,4,5; sixth read returns 0; STATUS bit3=1, bit0=1.
- Stream 16 samples without tlast, DEPTH=16 -> sm_tready=0 with tvalid held; STATUS bit1=1. One DATA read -> exactly one further sample accepted.
- Continuous push with a DATA read every 2 cycles -> occupancy stays constant during overlap cycles; data order is preserved with no loss or duplication.
- In HOLD write CTRL=0x2 -> state RUN, FIFO contents kept, COUNT continues. Then write CTRL=0x1 -> occupancy 0, COUNT 0, underflow 0, done_irq 0.
- With FIR_OUT_COLLECTOR_CKSUM_EN, push 0xFFFF_FFFF and 0x2 -> CKSUM=0x0000_0001. Without the macro, CKSUM reads 0.

Source files
------------

// File: rtl/fir_out_collector_pkg.sv
// fir_out_collector_pkg: register map, status/control bit positions and state
// encoding shared by the collector top and its testbench.
// Contents: ADR_* offsets, ST_* / CTRL_* bit positions, state_t, status_word().
package fir_out_collector_pkg;

    // Register offsets, decoded from wbs_adr_i[3:2]
    localparam logic [1:0] ADR_DATA   = 2'd0;
    localparam logic [1:0] ADR_STATUS = 2'd1;
    localparam logic [1:0] ADR_CTRL   = 2'd1;  // write side of the STATUS slot
    localparam logic [1:0] ADR_COUNT  = 2'd2;
    localparam logic [1:0] ADR_CKSUM  = 2'd3;

    // STATUS bit positions
    localparam int ST_EMPTY     = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_DONE      = 2;
    localparam int ST_UNDERFLOW = 3;
    localparam int ST_OCC_LSB   = 8;

    // CTRL bit positions
    localparam int CTRL_CLEAR = 0;
    localparam int CTRL_REARM = 1;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_t;

    function automatic logic [31:0] status_word(input logic       empty,
                                                input logic       full,
                                                input logic       done,
                                                input logic       underflow,
                                                input logic [7:0] occ);
        logic [31:0] w;
        w                  = '0;
        w[ST_EMPTY]        = empty;
        w[ST_FULL]         = full;
        w[ST_DONE]         = done;
        w[ST_UNDERFLOW]    = underflow;
        w[ST_OCC_LSB +: 8] = occ;
        return w;
    endfunction

endpackage

// File: rtl/fir_out_collector_if.sv
// fir_out_collector_if: bundles the Wishbone slave bus and the AXI-Stream sink
// signals of the collector. slave = collector side, master = CPU/upstream side.
// Signals: wbs_{stb,cyc,we,sel,dat,adr}_i, wbs_{ack,dat}_o, sm_{tvalid,tdata,tlast,tready}.
interface fir_out_collector_if #(
    parameter int pDATA_WIDTH = 32
);
    logic                   wbs_stb_i;
    logic                   wbs_cyc_i;
    logic                   wbs_we_i;
    logic [3:0]             wbs_sel_i;
    logic [31:0]            wbs_dat_i;
    logic [31:0]            wbs_adr_i;
    logic                   wbs_ack_o;
    logic [31:0]            wbs_dat_o;

    logic                   sm_tvalid;
    logic [pDATA_WIDTH-1:0] sm_tdata;
    logic                   sm_tlast;
    logic                   sm_tready;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        output wbs_ack_o, wbs_dat_o,
        input  sm_tvalid, sm_tdata, sm_tlast,
        output sm_tready
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_dat_i, wbs_adr_i,
        input  wbs_ack_o, wbs_dat_o,
        output sm_tvalid, sm_tdata, sm_tlast,
        input  sm_tready
    );
endinterface

// File: rtl/fir_out_collector_sync_fifo.sv
// Generic synchronous FIFO with flush; head is presented combinationally.
// Latency: a push is visible at pop_dat/occ on the cycle after it is written; no bypass.
// Backpressure: push ignored while full, pop ignored while empty; flush beats both.
// Ports: clk, rst, push/push_dat, pop/pop_dat, flush, full, empty, occ.
module fir_out_collector_sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_dat,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      occ
);
    localparam logic [AW:0] FULL_OCC = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      occ_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (occ_q == FULL_OCC);
    assign empty   = (occ_q == '0);
    assign occ     = occ_q;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            occ_q  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            // Simultaneous push and pop leave occupancy unchanged
            case ({do_push, do_pop})
                2'b10:   occ_q <= occ_q + 1'b1;
                2'b01:   occ_q <= occ_q - 1'b1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // Storage is not reset; only entries between the pointers are ever read
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/fir_out_collector.sv
// fir_out_collector: captures one run of FIR output samples into a FIFO and
// exposes FIFO head, status, sample count and done flag over Wishbone.
// Latency: sample readable at DATA from the next access issued >=1 cycle after accept; ack 1 cycle.
// Backpressure: sm_tready = RUN && !full (registered state only); drops after tlast until CTRL rearm/clear.
// Ports: clk, rst (sync, active-high), bus (Wishbone slave + stream sink), done_irq (level, = DONE).
// Optional: define FIR_OUT_COLLECTOR_CKSUM_EN for a 32-bit running sum of accepted samples at CKSUM.
module fir_out_collector
    import fir_out_collector_pkg::*;
#(
    parameter int pDATA_WIDTH = 32,
    parameter int DEPTH       = 16,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst,
    fir_out_collector_if.slave  bus,
    output logic                done_irq
);
    localparam int AW = $clog2(DEPTH);

    state_t                 state_q;
    state_t                 state_d;
    logic                   tready;
    logic                   accept;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [AW:0]            fifo_occ;
    logic [pDATA_WIDTH-1:0] fifo_head;
    logic                   fifo_pop;

    logic                   ack_q;
    logic [31:0]            dat_q;
    logic [CNT_WIDTH-1:0]   count_q;
    logic                   underflow_q;

    logic                   wb_req;
    logic                   wb_rd;
    logic                   wb_wr;
    logic [1:0]             adr_sel;
    logic                   ctrl_wr;
    logic                   ctrl_clear;
    logic                   ctrl_rearm;
    logic                   data_rd;
    logic [15:0]            occ_wide;
    logic [31:0]            rd_word;
    logic [31:0]            cksum_word;

    // ------------------------------------------------------------------
    // Wishbone request decode; the registered ack masks the second cycle
    // of a held strobe so every access is taken exactly once.
    // ------------------------------------------------------------------
    assign wb_req     = bus.wbs_stb_i && bus.wbs_cyc_i && !ack_q;
    assign wb_rd      = wb_req && !bus.wbs_we_i;
    assign wb_wr      = wb_req &&  bus.wbs_we_i;
    assign adr_sel    = bus.wbs_adr_i[3:2];
    assign ctrl_wr    = wb_wr && (adr_sel == ADR_CTRL) && bus.wbs_sel_i[0];
    assign ctrl_clear = ctrl_wr && bus.wbs_dat_i[CTRL_CLEAR];
    assign ctrl_rearm = ctrl_wr && bus.wbs_dat_i[CTRL_REARM];
    assign data_rd    = wb_rd && (adr_sel == ADR_DATA);
    assign fifo_pop   = data_rd && !fifo_empty;
    assign accept     = bus.sm_tvalid && tready;

    // ------------------------------------------------------------------
    // FSM: state register / next state / outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= RUN;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            // A clear racing the tlast push drops that sample, so stay in RUN
            RUN:  if (accept && bus.sm_tlast && !ctrl_clear) state_d = HOLD;
            HOLD: if (ctrl_clear || ctrl_rearm)             state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        tready   = (state_q == RUN) && !fifo_full;
        done_irq = (state_q == HOLD);
    end

    assign bus.sm_tready = tready;

    // ------------------------------------------------------------------
    // Sample storage
    // ------------------------------------------------------------------
    fir_out_collector_sync_fifo #(
        .WIDTH (pDATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (accept),
        .push_dat (bus.sm_tdata),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .flush    (ctrl_clear),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .occ      (fifo_occ)
    );

    // ------------------------------------------------------------------
    // Optional running checksum
    // ------------------------------------------------------------------
`ifdef FIR_OUT_COLLECTOR_CKSUM_EN
    logic [31:0] cksum_q;

    always_ff @(posedge clk) begin
        if (rst || ctrl_clear) cksum_q <= '0;
        else if (accept)       cksum_q <= cksum_q + 32'(bus.sm_tdata);
    end

    assign cksum_word = cksum_q;
`else
    assign cksum_word = '0;
`endif

    // ------------------------------------------------------------------
    // Read mux. Occupancy is shown in 8 bits; at DEPTH=256 a full FIFO
    // reads 0 there and the FULL bit disambiguates.
    // ------------------------------------------------------------------
    assign occ_wide = 16'(fifo_occ);

    always_comb begin
        rd_word = '0;
        case (adr_sel)
            ADR_DATA:   if (!fifo_empty) rd_word = 32'(fifo_head);
            ADR_STATUS: rd_word = status_word(fifo_empty, fifo_full, done_irq,
                                              underflow_q, occ_wide[7:0]);
            ADR_COUNT:  rd_word = 32'(count_q);
            ADR_CKSUM:  rd_word = cksum_word;
            default:    rd_word = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ack_q       <= 1'b0;
            dat_q       <= '0;
            count_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            ack_q <= wb_req;
            dat_q <= wb_rd ? rd_word : '0;

            if (ctrl_clear)  count_q <= '0;
            else if (accept) count_q <= count_q + CNT_WIDTH'(1);

            if (ctrl_clear)                 underflow_q <= 1'b0;
            else if (data_rd && fifo_empty) underflow_q <= 1'b1;
        end
    end

    assign bus.wbs_ack_o = ack_q;
    assign bus.wbs_dat_o = dat_q;

    // Address/data/select bits outside the decoded fields
    logic unused_bits;
    assign unused_bits = ^{bus.wbs_dat_i[31:2], bus.wbs_sel_i[3:1],
                           bus.wbs_adr_i[31:4], bus.wbs_adr_i[1:0], occ_wide[15:8]};

endmodule

// File: tb/tb_fir_out_collector.sv
// tb_fir_out_collector: directed bench for fir_out_collector (DEPTH=16).
// Accepted samples go into an expected-data queue; DATA reads pop and compare.
// Status/count/checksum expectations come from a small bench-side model.
module tb_fir_out_collector;
    import fir_out_collector_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic done_irq;

    always #5 clk = ~clk;

    fir_out_collector_if #(.pDATA_WIDTH(32)) bus ();

    fir_out_collector #(
        .pDATA_WIDTH (32),
        .DEPTH       (16),
        .CNT_WIDTH   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .done_irq (done_irq)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          exp_cnt = 0;
    logic [31:0] exp_ck  = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input int occ, input bit done, input bit uf);
        logic [31:0] w;
        w        = '0;
        w[0]     = (occ == 0);
        w[1]     = (occ == 16);
        w[2]     = done;
        w[3]     = uf;
        w[15:8]  = 8'(occ);
        return w;
    endfunction

    // One Wishbone access; waits (bounded) for ack, samples #1 after the edge
    task automatic wb_xfer(input logic we, input logic [1:0] a, input logic [31:0] wd,
                           input logic [3:0] sel, output logic [31:0] rdat);
        int n;
        n             = 0;
        bus.wbs_stb_i = 1'b1;
        bus.wbs_cyc_i = 1'b1;
        bus.wbs_we_i  = we;
        bus.wbs_adr_i = {28'd0, a, 2'b00};
        bus.wbs_dat_i = wd;
        bus.wbs_sel_i = sel;
        rdat          = '0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (!bus.wbs_ack_o && n < 8);
        chk("wb_ack", {31'd0, bus.wbs_ack_o}, 32'd1);
        if (bus.wbs_ack_o) rdat = bus.wbs_dat_o;
        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
    endtask

    task automatic wb_read(input logic [1:0] a, output logic [31:0] rdat);
        wb_xfer(1'b0, a, 32'd0, 4'hF, rdat);
    endtask

    task automatic wb_write(input logic [1:0] a, input logic [31:0] wd, input logic [3:0] sel);
        logic [31:0] dummy;
        wb_xfer(1'b1, a, wd, sel, dummy);
    endtask

    // DATA read compared against the scoreboard head (0 if nothing expected)
    task automatic read_data_chk(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        wb_read(ADR_DATA, d);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'd0;
        chk(tag, d, e);
    endtask

    // Present one sample; tready is sampled #1 after an edge and is stable
    // until the next edge, where the handshake completes.
    task automatic push_sample(input logic [31:0] d, input logic last);
        int n;
        bit acc;
        n             = 0;
        acc           = 1'b0;
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = d;
        bus.sm_tlast  = last;
        while (!acc && n < 50) begin
            acc = bus.sm_tready;
            @(posedge clk); #1;
            n++;
        end
        bus.sm_tvalid = 1'b0;
        bus.sm_tlast  = 1'b0;
        chk("push_accept", {31'd0, acc}, 32'd1);
        if (acc) begin
            exp_q.push_back(d);
            exp_cnt++;
            exp_ck += d;
        end
    endtask

    task automatic model_clear();
        exp_q.delete();
        exp_cnt = 0;
        exp_ck  = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end of the sequence");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd;
        logic [31:0] ck_exp;

        bus.wbs_stb_i = 1'b0;
        bus.wbs_cyc_i = 1'b0;
        bus.wbs_we_i  = 1'b0;
        bus.wbs_sel_i = 4'h0;
        bus.wbs_dat_i = '0;
        bus.wbs_adr_i = '0;
        bus.sm_tvalid = 1'b0;
        bus.sm_tdata  = '0;
        bus.sm_tlast  = 1'b0;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack",      {31'd0, bus.wbs_ack_o}, 32'd0);
        chk("rst_dat",      bus.wbs_dat_o,          32'd0);
        chk("rst_done_irq", {31'd0, done_irq},      32'd0);
        chk("rst_tready",   {31'd0, bus.sm_tready}, 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;

        // ---- run of 5 samples ending in tlast ----
        for (int i = 1; i <= 5; i++) push_sample(32'(i), i == 5);
        chk("tlast_tready",   {31'd0, bus.sm_tready}, 32'd0);
        chk("tlast_done_irq", {31'd0, done_irq},      32'd1);
        wb_read(ADR_STATUS, rd);
        chk("run5_status", rd, 32'h0000_0504);
        chk("run5_status_model", rd, exp_status(exp_q.size(), 1'b1, 1'b0));
        wb_read(ADR_COUNT, rd);
        chk("run5_count", rd, 32'(exp_cnt));
        @(posedge clk); #1;
        chk("ack_one_cycle", {31'd0, bus.wbs_ack_o}, 32'd0);

        // ---- drain, then underflow ----
        for (int i = 0; i < 5; i++) read_data_chk("run5_data");
        read_data_chk("underflow_data");
        wb_read(ADR_STATUS, rd);
        chk("underflow_status", rd, exp_status(0, 1'b1, 1'b1));

        // ---- CTRL without byte 0 enabled is ignored ----
        wb_write(ADR_CTRL, 32'h2, 4'hE);
        chk("ctrl_nosel_done", {31'd0, done_irq}, 32'd1);

        // ---- rearm keeps FIFO and count ----
        wb_write(ADR_CTRL, 32'h2, 4'h1);
        chk("rearm_done_irq", {31'd0, done_irq},      32'd0);
        chk("rearm_tready",   {31'd0, bus.sm_tready}, 32'd1);
        push_sample(32'h10, 1'b0);
        push_sample(32'h11, 1'b1);
        wb_read(ADR_STATUS, rd);
        chk("hold2_status", rd, exp_status(2, 1'b1, 1'b1));
        wb_write(ADR_CTRL, 32'h2, 4'h1);
        wb_read(ADR_STATUS, rd);
        chk("rearm2_status", rd, exp_status(2, 1'b0, 1'b1));
        wb_read(ADR_COUNT, rd);
        chk("rearm_count", rd, 32'(exp_cnt));
        read_data_chk("rearm_kept_data");

        // ---- clear flushes everything ----
        wb_write(ADR_CTRL, 32'h1, 4'h1);
        model_clear();
        wb_read(ADR_STATUS, rd);
        chk("clear_status", rd, exp_status(0, 1'b0, 1'b0));
        wb_read(ADR_COUNT, rd);
        chk("clear_count", rd, 32'd0);
        chk("clear_done_irq", {31'd0, done_irq}, 32'd0);

        // ---- fill to DEPTH, backpressure, one pop admits one sample ----
        for (int i = 0; i < 16; i++) push_sample(32'h100 + 32'(i), 1'b0);
        wb_read(ADR_STATUS, rd);
        chk("full_status", rd, 32'h0000_1002);
        bus.sm_tvalid = 1'b1;
        bus.sm_tdata  = 32'h200;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("full_tready", {31'd0, bus.sm_tready}, 32'd0);
        end
        read_data_chk("full_pop_data");
        push_sample(32'h200, 1'b0);
        chk("refull_tready", {31'd0, bus.sm_tready}, 32'd0);
        wb_read(ADR_STATUS, rd);
        chk("refull_status", rd, exp_status(16, 1'b0, 1'b0));
        while (exp_q.size() > 0) read_data_chk("full_drain_data");
        wb_read(ADR_STATUS, rd);
        chk("drained_status", rd, exp_status(0, 1'b0, 1'b0));

        // ---- continuous push overlapped with DATA reads ----
        for (int i = 0; i < 8; i++) push_sample(32'h300 + 32'(i), 1'b0);
        fork
            begin
                for (int i = 0; i < 8; i++) push_sample(32'h310 + 32'(i), 1'b0);
            end
            begin
                for (int j = 0; j < 4; j++) read_data_chk("overlap_data");
            end
        join
        wb_read(ADR_STATUS, rd);
        chk("overlap_status", rd, exp_status(exp_q.size(), 1'b0, 1'b0));
        while (exp_q.size() > 0) read_data_chk("overlap_drain_data");
        wb_read(ADR_COUNT, rd);
        chk("overlap_count", rd, 32'(exp_cnt));

        // ---- clear beats rearm when both bits are written ----
        push_sample(32'h55, 1'b1);
        wb_write(ADR_CTRL, 32'h3, 4'h1);
        model_clear();
        wb_read(ADR_STATUS, rd);
        chk("clear_rearm_status", rd, exp_status(0, 1'b0, 1'b0));

        // ---- checksum wraps modulo 2^32 ----
        push_sample(32'hFFFF_FFFF, 1'b0);
        push_sample(32'h0000_0002, 1'b0);
        ck_exp = exp_ck;
`ifndef FIR_OUT_COLLECTOR_CKSUM_EN
        ck_exp = 32'd0;
`endif
        wb_read(ADR_CKSUM, rd);
        chk("cksum", rd, ck_exp);
        wb_read(ADR_COUNT, rd);
        chk("cksum_count", rd, 32'(exp_cnt));

        // ---- writes to read-only slots are ignored ----
        wb_write(ADR_DATA,  32'hDEAD_BEEF, 4'hF);
        wb_write(ADR_COUNT, 32'h0000_0000, 4'hF);
        wb_read(ADR_STATUS, rd);
        chk("ro_write_status", rd, exp_status(exp_q.size(), 1'b0, 1'b0));
        wb_read(ADR_COUNT, rd);
        chk("ro_write_count", rd, 32'(exp_cnt));
        read_data_chk("ro_write_data");
        read_data_chk("ro_write_data");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
